// File: rtl/cpu_pkg.sv
// Shared CPU constants and the fetch-state encoding used by the instruction
// fetch path and its neighbours.
package cpu_pkg;

  localparam int ADDR_W = 8;
  localparam int INSTR_W = 16;
  localparam logic [15:0] HALT_WORD = 16'h0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, reads a 16-bit little-endian word from the
// combinational instruction memory and hands it to decode via a one-entry skid register.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                 ADDR_W    = cpu_pkg::ADDR_W,
  parameter int                 INSTR_W   = cpu_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0]  RESET_PC  = {ADDR_W{1'b0}},
  parameter logic [INSTR_W-1:0] HALT_WORD = cpu_pkg::HALT_WORD
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               run,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               ir_valid,
  input  logic               id_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted,
  output logic [15:0]        fetch_count
);

  fetch_state_e       state_r, state_s;
  logic [ADDR_W-1:0]  pc_r, pc_s;
  logic [INSTR_W-1:0] ir_r, ir_s;
  logic [ADDR_W-1:0]  ir_pc_r, ir_pc_s;
  logic               ir_valid_r, ir_valid_s;
  logic [15:0]        fetch_count_r, fetch_count_s;
  logic               take_s;
  logic [ADDR_W-1:0]  target_s;

  // Next-state, PC, skid-register and counter logic.
  always_comb begin
    state_s       = state_r;
    pc_s          = pc_r;
    ir_s          = ir_r;
    ir_pc_s       = ir_pc_r;
    ir_valid_s    = ir_valid_r;
    fetch_count_s = fetch_count_r;
    target_s      = {redirect_pc[ADDR_W-1:1], 1'b0};
    take_s        = (state_r == FETCH) && (!ir_valid_r || id_ready) && !redirect_valid;

    case (state_r)
      IDLE: begin
        // A redirect before the core starts only preloads the PC.
        if (redirect_valid) begin
          pc_s = target_s;
        end else begin
          pc_s = pc_r;
        end
        if (run) begin
          state_s = FETCH;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH, HALT: begin
        if (redirect_valid) begin
          // Flush wins over a same-cycle accept; a HALT on the squashed path is undone.
          pc_s       = target_s;
          ir_valid_s = 1'b0;
          state_s    = FETCH;
        end else if (take_s) begin
          ir_s       = imem_data;
          ir_pc_s    = pc_r;
          ir_valid_s = 1'b1;
          if (fetch_count_r == 16'hFFFF) begin
            fetch_count_s = fetch_count_r;
          end else begin
            fetch_count_s = fetch_count_r + 16'd1;
          end
          if (imem_data == HALT_WORD) begin
            pc_s    = pc_r;
            state_s = HALT;
          end else begin
            pc_s    = pc_r + ADDR_W'(2);
            state_s = state_r;
          end
        end else if (ir_valid_r && id_ready) begin
          ir_valid_s = 1'b0;
        end else begin
          ir_valid_s = ir_valid_r;
        end
      end
      default: begin
        state_s    = IDLE;
        ir_valid_s = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      pc_r          <= RESET_PC;
      ir_r          <= {INSTR_W{1'b0}};
      ir_pc_r       <= {ADDR_W{1'b0}};
      ir_valid_r    <= 1'b0;
      fetch_count_r <= 16'd0;
    end else begin
      state_r       <= state_s;
      pc_r          <= pc_s;
      ir_r          <= ir_s;
      ir_pc_r       <= ir_pc_s;
      ir_valid_r    <= ir_valid_s;
      fetch_count_r <= fetch_count_s;
    end
  end

  assign imem_addr   = pc_r;
  assign pc          = pc_r;
  assign ir          = ir_r;
  assign ir_pc       = ir_pc_r;
  assign ir_valid    = ir_valid_r;
  assign halted      = (state_r == HALT);
  assign fetch_count = fetch_count_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table for the documented scenarios,
// an asynchronous-reset probe, then randomized traffic against a behavioural model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        run;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic [15:0] ir;
  logic [7:0]  ir_pc;
  logic        ir_valid;
  logic        id_ready;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic [7:0]  pc;
  logic        halted;
  logic [15:0] fetch_count;

  logic [7:0]  mem [256];
  logic [7:0]  addr_hi;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign addr_hi   = imem_addr + 8'd1;
  assign imem_data = {mem[addr_hi], mem[imem_addr]};

  instr_fetch_unit dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .run            (run),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .ir             (ir),
    .ir_pc          (ir_pc),
    .ir_valid       (ir_valid),
    .id_ready       (id_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  typedef struct {
    logic        run;
    logic        rdy;
    logic        rv;
    logic [7:0]  rpc;
    logic [15:0] e_ir;
    logic [7:0]  e_ir_pc;
    logic        e_valid;
    logic [7:0]  e_pc;
    logic        e_halted;
    logic [15:0] e_count;
  } vec_t;

  vec_t vecs [17];

  // Behavioural model state
  bit          m_started;
  bit          m_halted;
  bit          m_valid;
  logic [7:0]  m_pc;
  logic [15:0] m_ir;
  logic [7:0]  m_ir_pc;
  int          m_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_started = 0; m_halted = 0; m_valid = 0;
    m_pc = 8'h00; m_ir = 16'h0000; m_ir_pc = 8'h00; m_count = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_tick();
    logic [7:0]  a1;
    logic [15:0] word;
    a1   = m_pc + 8'd1;
    word = {mem[a1], mem[m_pc]};
    if (!m_started) begin
      if (redirect_valid) m_pc = {redirect_pc[7:1], 1'b0};
      if (run) m_started = 1;
    end else if (redirect_valid) begin
      m_pc = {redirect_pc[7:1], 1'b0};
      m_valid = 0;
      m_halted = 0;
    end else if (!m_halted && (!m_valid || id_ready)) begin
      m_ir = word;
      m_ir_pc = m_pc;
      m_valid = 1;
      if (m_count < 65535) m_count = m_count + 1;
      if (word == 16'h0000) m_halted = 1;
      else m_pc = m_pc + 8'd2;
    end else if (m_valid && id_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic model_compare();
    chk("ir", 32'(ir), 32'(m_ir));
    chk("ir_pc", 32'(ir_pc), 32'(m_ir_pc));
    chk("ir_valid", 32'(ir_valid), 32'(m_valid));
    chk("pc", 32'(pc), 32'(m_pc));
    chk("imem_addr", 32'(imem_addr), 32'(m_pc));
    chk("halted", 32'(halted), 32'(m_halted));
    chk("fetch_count", 32'(fetch_count), 32'(m_count));
  endtask

  task automatic do_reset();
    reset_n = 1'b0; run = 1'b0; id_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 8'h00;
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) | 8'h01;
    mem[0] = 8'h21; mem[1] = 8'hFE; mem[2] = 8'h22; mem[3] = 8'hFB;
    mem[62] = 8'h00; mem[63] = 8'h00;

    //            run   rdy   rv    rpc    ir        ir_pc  vld   pc     hlt   cnt
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 16'h0000, 8'h00, 1'b0, 8'h00, 1'b0, 16'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 8'h00, 16'hFE21, 8'h00, 1'b1, 8'h02, 1'b0, 16'd1};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 16'hFE21, 8'h00, 1'b1, 8'h02, 1'b0, 16'd1};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 16'hFE21, 8'h00, 1'b1, 8'h02, 1'b0, 16'd1};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 16'hFE21, 8'h00, 1'b1, 8'h02, 1'b0, 16'd1};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 16'hFB22, 8'h02, 1'b1, 8'h04, 1'b0, 16'd2};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'h23, 16'hFB22, 8'h02, 1'b0, 8'h22, 1'b0, 16'd2};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 16'h2323, 8'h22, 1'b1, 8'h24, 1'b0, 16'd3};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 8'h3E, 16'h2323, 8'h22, 1'b0, 8'h3E, 1'b0, 16'd3};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 16'h0000, 8'h3E, 1'b1, 8'h3E, 1'b1, 16'd4};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 8'h3E, 1'b1, 8'h3E, 1'b1, 16'd4};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 8'h00, 16'h0000, 8'h3E, 1'b0, 8'h3E, 1'b1, 16'd4};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 8'h00, 16'h0000, 8'h3E, 1'b0, 8'h3E, 1'b1, 16'd4};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 8'h10, 16'h0000, 8'h3E, 1'b0, 8'h10, 1'b0, 16'd4};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 8'h00, 16'h1111, 8'h10, 1'b1, 8'h12, 1'b0, 16'd5};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 8'hFF, 16'h1111, 8'h10, 1'b0, 8'hFE, 1'b0, 16'd5};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 8'h00, 16'hFFFF, 8'hFE, 1'b1, 8'h00, 1'b0, 16'd6};

    do_reset();
    chk("reset_ir", 32'(ir), 32'h0);
    chk("reset_ir_valid", 32'(ir_valid), 32'h0);
    chk("reset_pc", 32'(pc), 32'h0);
    chk("reset_halted", 32'(halted), 32'h0);
    chk("reset_count", 32'(fetch_count), 32'h0);

    for (int v = 0; v < 17; v++) begin
      run = vecs[v].run; id_ready = vecs[v].rdy;
      redirect_valid = vecs[v].rv; redirect_pc = vecs[v].rpc;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_ir", v), 32'(ir), 32'(vecs[v].e_ir));
      chk($sformatf("vec%0d_ir_pc", v), 32'(ir_pc), 32'(vecs[v].e_ir_pc));
      chk($sformatf("vec%0d_ir_valid", v), 32'(ir_valid), 32'(vecs[v].e_valid));
      chk($sformatf("vec%0d_pc", v), 32'(pc), 32'(vecs[v].e_pc));
      chk($sformatf("vec%0d_imem_addr", v), 32'(imem_addr), 32'(vecs[v].e_pc));
      chk($sformatf("vec%0d_halted", v), 32'(halted), 32'(vecs[v].e_halted));
      chk($sformatf("vec%0d_count", v), 32'(fetch_count), 32'(vecs[v].e_count));
    end

    // Asynchronous reset mid-run: outputs must clear between clock edges.
    run = 1'b0; redirect_valid = 1'b0; id_ready = 1'b0;
    #1;
    reset_n = 1'b0;
    #2;
    chk("async_ir", 32'(ir), 32'h0);
    chk("async_ir_pc", 32'(ir_pc), 32'h0);
    chk("async_ir_valid", 32'(ir_valid), 32'h0);
    chk("async_pc", 32'(pc), 32'h0);
    chk("async_halted", 32'(halted), 32'h0);
    chk("async_count", 32'(fetch_count), 32'h0);

    // Randomized traffic against the behavioural model.
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 256; i += 2) begin
      if ($urandom_range(0, 19) == 0) begin
        mem[i] = 8'h00; mem[i+1] = 8'h00;
      end
    end
    do_reset();
    model_reset();
    model_compare();
    for (int c = 0; c < 3000; c++) begin
      run            = ($urandom_range(0, 3) != 0);
      id_ready       = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = 8'($urandom_range(0, 255));
      if (!m_started && run) redirect_valid = 1'b0;
      model_tick();
      @(posedge clk);
      #1;
      model_compare();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
